// File: rtl/ext_r_gen_ipa.sv
// Purpose  : turns one AXI-style AR burst into single-word local memory reads and streams the words back as R beats.
// Latency  : AR handshake in cycle 0, memory request in cycle 1, first R beat in cycle 3 when granted at once; 1 beat/cycle sustained.
// Backpressure: at most 2 reads outstanding beyond the last R pop (in flight + buffered); mem_req is withheld until a pop frees a slot.
//
// Ports:
//   clk_i, rst_ni                   clock, synchronous active-low reset
//   ar_valid_i/ar_ready_o/ar_*_i    read request (id, byte address, len = beats-1, user)
//   mem_req_o/mem_addr_o/mem_gnt_i  word-aligned read request to local memory
//   mem_rvalid_i/mem_rdata_i/err_i  read response, exactly one cycle after the grant
//   master_*                        R beat stream (data, resp, user, id, last) towards the R buffer
module ext_r_gen_ipa #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]            ar_len_i,
    input  logic [USER_WIDTH-1:0] ar_user_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i,
    output logic                  master_valid_o,
    output logic [DATA_WIDTH-1:0] master_data_o,
    output logic [1:0]            master_resp_o,
    output logic [USER_WIDTH-1:0] master_user_o,
    output logic [ID_WIDTH-1:0]   master_id_o,
    output logic                  master_last_o,
    input  logic                  master_ready_i
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_STEP - ADDR_WIDTH'(1));

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } beat_t;

    state_t state, state_next;

    logic [ID_WIDTH-1:0]   id_q;
    logic [USER_WIDTH-1:0] user_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            push_idx;
    logic [8:0]            req_left;
    logic [8:0]            beat_left;
    logic                  inflight;

    beat_t                 fifo_mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            occ;

    logic                  ar_fire;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [2:0]            credit;
    beat_t                 head;

    assign ar_fire = ar_valid_i & ar_ready_o;
    assign pop     = master_valid_o & master_ready_i;
    // Only a response to a grant we actually made is accepted; this also drops a
    // response that straddles a reset, since inflight is cleared by it.
    assign push    = mem_rvalid_i & inflight;
    // Slots committed for the next cycle: the read in flight plus buffered beats,
    // minus the beat leaving now. Using pop here lets a full FIFO still issue at full rate.
    assign credit  = {2'b00, inflight} + {1'b0, occ} - {2'b00, pop};
    assign issue   = mem_req_o & mem_gnt_i;

    assign mem_req_o  = (state == BURST) && (req_left != 9'd0) && (credit < 3'd2);
    assign mem_addr_o = addr_q;

    assign head           = fifo_mem[rd_ptr];
    assign master_valid_o = (occ != 2'd0);
    assign master_data_o  = head.data;
    assign master_resp_o  = master_valid_o ? head.resp : 2'b00;
    assign master_last_o  = master_valid_o & head.last;
    assign master_id_o    = id_q;
    assign master_user_o  = user_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ar_ready_o = 1'b0;
        case (state)
            IDLE: begin
                ar_ready_o = 1'b1;
                if (ar_valid_i) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (pop && (beat_left == 9'd1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            id_q        <= '0;
            user_q      <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            push_idx    <= '0;
            req_left    <= '0;
            beat_left   <= '0;
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            occ         <= '0;
        end else begin
            inflight <= issue;

            if (ar_fire) begin
                id_q      <= ar_id_i;
                user_q    <= ar_user_i;
                addr_q    <= ar_addr_i & ALIGN_MASK;
                len_q     <= ar_len_i;
                push_idx  <= '0;
                req_left  <= {1'b0, ar_len_i} + 9'd1;
                beat_left <= {1'b0, ar_len_i} + 9'd1;
            end else begin
                if (issue) begin
                    addr_q   <= addr_q + ADDR_STEP;
                    req_left <= req_left - 9'd1;
                end
                if (pop) begin
                    beat_left <= beat_left - 9'd1;
                end
                if (push) begin
                    push_idx <= push_idx + 8'd1;
                end
            end

            // The issue rule guarantees a free slot whenever a response arrives.
            if (push) begin
                fifo_mem[wr_ptr] <= '{data: mem_rdata_i,
                                      resp: mem_err_i ? 2'b10 : 2'b00,
                                      last: (push_idx == len_q)};
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ext_r_gen_ipa.sv
module tb_ext_r_gen_ipa;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ar_valid_i = 1'b0;
    logic        ar_ready_o;
    logic [3:0]  ar_id_i = '0;
    logic [31:0] ar_addr_i = '0;
    logic [7:0]  ar_len_i = '0;
    logic [5:0]  ar_user_i = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b1;
    logic        mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
    logic        mem_err_i = 1'b0;
    logic        master_valid_o;
    logic [63:0] master_data_o;
    logic [1:0]  master_resp_o;
    logic [5:0]  master_user_o;
    logic [3:0]  master_id_o;
    logic        master_last_o;
    logic        master_ready_i = 1'b1;

    ext_r_gen_ipa dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .ar_valid_i     (ar_valid_i),
        .ar_ready_o     (ar_ready_o),
        .ar_id_i        (ar_id_i),
        .ar_addr_i      (ar_addr_i),
        .ar_len_i       (ar_len_i),
        .ar_user_i      (ar_user_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_err_i      (mem_err_i),
        .master_valid_o (master_valid_o),
        .master_data_o  (master_data_o),
        .master_resp_o  (master_resp_o),
        .master_user_o  (master_user_o),
        .master_id_o    (master_id_o),
        .master_last_o  (master_last_o),
        .master_ready_i (master_ready_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Logs filled by the monitor
    logic [31:0] g_addr[$];
    int          g_cyc[$];
    logic [31:0] rq_addr[$];
    logic [63:0] b_data[$];
    logic [1:0]  b_resp[$];
    logic        b_last[$];
    logic [3:0]  b_id[$];
    logic [5:0]  b_user[$];
    int          b_cyc[$];

    // Memory model state
    int          err_at = -1;
    int          stall_at = -1;
    int          stall_left = 0;
    logic        pend = 1'b0;
    logic [63:0] pend_data = '0;
    logic        pend_err = 1'b0;

    logic        hold_prev = 1'b0;
    logic [63:0] hold_dat = '0;
    int          hold_bad = 0;
    int          ar_cyc = 0;

    function automatic logic [63:0] mdat(input logic [31:0] a);
        return {a ^ 32'hA5A5_5A5A, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Memory: grants per stall policy, answers one cycle after each grant
    initial forever begin
        @(posedge clk);
        #1;
        mem_rvalid_i = pend;
        mem_rdata_i  = pend_data;
        mem_err_i    = pend_err;
        mem_gnt_i    = !(stall_left > 0 && g_addr.size() == stall_at);
    end

    always @(negedge clk) begin
        if (rst_ni && mem_req_o) rq_addr.push_back(mem_addr_o);
        if (rst_ni && mem_req_o && !mem_gnt_i && stall_left > 0) stall_left--;
        if (mem_req_o && mem_gnt_i) begin
            pend      = 1'b1;
            pend_data = mdat(mem_addr_o);
            pend_err  = (g_addr.size() == err_at);
            if (rst_ni) begin
                g_addr.push_back(mem_addr_o);
                g_cyc.push_back(cyc);
            end
        end else begin
            pend = 1'b0;
        end
        if (rst_ni && master_valid_o && master_ready_i) begin
            b_data.push_back(master_data_o);
            b_resp.push_back(master_resp_o);
            b_last.push_back(master_last_o);
            b_id.push_back(master_id_o);
            b_user.push_back(master_user_o);
            b_cyc.push_back(cyc);
        end
        if (rst_ni && hold_prev && master_data_o !== hold_dat) hold_bad++;
        hold_prev = rst_ni && master_valid_o && !master_ready_i;
        hold_dat  = master_data_o;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_logs();
        g_addr.delete(); g_cyc.delete(); rq_addr.delete();
        b_data.delete(); b_resp.delete(); b_last.delete();
        b_id.delete(); b_user.delete(); b_cyc.delete();
        err_at = -1; stall_at = -1; stall_left = 0; hold_bad = 0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [5:0] user);
        int t;
        ar_id_i = id; ar_addr_i = addr; ar_len_i = len; ar_user_i = user;
        ar_valid_i = 1'b1;
        t = 0;
        while (!ar_ready_o && t < 50) begin
            step(1);
            t++;
        end
        check("ar_accept", 64'(ar_ready_o), 64'd1);
        ar_cyc = cyc;
        step(1);
        ar_valid_i = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int t;
        t = 0;
        while (b_data.size() < n && t < budget) begin
            step(1);
            t++;
        end
        check("beat_count_wait", 64'(b_data.size()), 64'(n));
    endtask

    initial begin
        logic [31:0] ea;
        int lasts;
        int t;

        // Reset
        step(2);
        check("rst_ar_ready", 64'(ar_ready_o), 64'd1);
        check("rst_mem_req", 64'(mem_req_o), 64'd0);
        check("rst_valid", 64'(master_valid_o), 64'd0);
        check("rst_last", 64'(master_last_o), 64'd0);
        check("rst_resp", 64'(master_resp_o), 64'd0);
        check("rst_data", master_data_o, 64'd0);
        check("rst_id", 64'(master_id_o), 64'd0);
        check("rst_user", 64'(master_user_o), 64'd0);
        rst_ni = 1'b1;
        step(2);

        // Single beat
        clear_logs();
        send_ar(4'd3, 32'h0000_1004, 8'd0, 6'd5);
        wait_beats(1, 20);
        check("t1_ready_after", 64'(ar_ready_o), 64'd1);
        check("t1_addr", 64'(g_addr[0]), 64'h1000);
        check("t1_req_cyc", 64'(g_cyc[0]), 64'(ar_cyc + 1));
        check("t1_beat_cyc", 64'(b_cyc[0]), 64'(ar_cyc + 3));
        check("t1_data", b_data[0], mdat(32'h1000));
        check("t1_last", 64'(b_last[0]), 64'd1);
        check("t1_resp", 64'(b_resp[0]), 64'd0);
        check("t1_id", 64'(b_id[0]), 64'd3);
        check("t1_user", 64'(b_user[0]), 64'd5);
        step(4);
        check("t1_nbeats", 64'(b_data.size()), 64'd1);

        // Full-rate burst
        clear_logs();
        send_ar(4'd5, 32'h0000_0100, 8'd3, 6'h2A);
        wait_beats(4, 20);
        step(4);
        check("t2_nbeats", 64'(b_data.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("t2_addr", 64'(g_addr[i]), 64'(32'h100 + 32'(8 * i)));
            check("t2_req_cyc", 64'(g_cyc[i]), 64'(ar_cyc + 1 + i));
            check("t2_beat_cyc", 64'(b_cyc[i]), 64'(ar_cyc + 3 + i));
            check("t2_data", b_data[i], mdat(32'h100 + 32'(8 * i)));
            check("t2_last", 64'(b_last[i]), 64'(i == 3));
            check("t2_id", 64'(b_id[i]), 64'd5);
        end

        // Backpressure
        clear_logs();
        send_ar(4'd7, 32'h0000_2000, 8'd7, 6'd1);
        t = 0;
        while (!master_valid_o && t < 20) begin
            step(1);
            t++;
        end
        check("t3_first_valid", 64'(master_valid_o), 64'd1);
        master_ready_i = 1'b0;
        step(10);
        check("t3_grants_stalled", 64'(g_addr.size()), 64'd2);
        check("t3_no_beats", 64'(b_data.size()), 64'd0);
        check("t3_valid_held", 64'(master_valid_o), 64'd1);
        master_ready_i = 1'b1;
        wait_beats(8, 40);
        step(4);
        check("t3_nbeats", 64'(b_data.size()), 64'd8);
        check("t3_hold_stable", 64'(hold_bad), 64'd0);
        for (int i = 0; i < 8; i++) begin
            check("t3_data", b_data[i], mdat(32'h2000 + 32'(8 * i)));
            check("t3_last", 64'(b_last[i]), 64'(i == 7));
        end

        // Grant stall on 2nd request, error on 3rd response
        clear_logs();
        stall_at = 1; stall_left = 3; err_at = 2;
        send_ar(4'd2, 32'h0000_0500, 8'd3, 6'd9);
        wait_beats(4, 40);
        step(4);
        check("t4_nbeats", 64'(b_data.size()), 64'd4);
        check("t4_nreq_cycles", 64'(rq_addr.size()), 64'd7);
        for (int i = 0; i < 7; i++) begin
            ea = 32'h500 + 32'(8 * ((i == 0) ? 0 : (i <= 4) ? 1 : i - 3));
            check("t4_req_addr", 64'(rq_addr[i]), 64'(ea));
        end
        for (int i = 0; i < 4; i++) begin
            check("t4_resp", 64'(b_resp[i]), (i == 2) ? 64'd2 : 64'd0);
            check("t4_data", b_data[i], mdat(32'h500 + 32'(8 * i)));
            check("t4_last", 64'(b_last[i]), 64'(i == 3));
        end

        // Address wrap, 256-beat burst
        clear_logs();
        send_ar(4'd1, 32'hFFFF_FFF8, 8'd255, 6'd3);
        wait_beats(256, 400);
        step(4);
        check("t5_nbeats", 64'(b_data.size()), 64'd256);
        check("t5_addr0", 64'(g_addr[0]), 64'hFFFF_FFF8);
        check("t5_addr1_wrap", 64'(g_addr[1]), 64'h0);
        lasts = 0;
        for (int i = 0; i < b_data.size(); i++) begin
            check("t5_data", b_data[i], mdat(32'hFFFF_FFF8 + 32'(8 * i)));
            if (b_last[i]) lasts++;
        end
        check("t5_last_count", 64'(lasts), 64'd1);
        check("t5_last_pos", 64'(b_last[255]), 64'd1);

        // Reset during beat 2
        clear_logs();
        send_ar(4'd6, 32'h0000_3000, 8'd7, 6'd2);
        wait_beats(1, 20);
        check("t6_beat2_valid", 64'(master_valid_o), 64'd1);
        rst_ni = 1'b0;
        step(1);
        rst_ni = 1'b1;
        check("t6_valid_after_rst", 64'(master_valid_o), 64'd0);
        check("t6_ready_after_rst", 64'(ar_ready_o), 64'd1);
        check("t6_req_after_rst", 64'(mem_req_o), 64'd0);
        clear_logs();
        send_ar(4'd9, 32'h0000_4000, 8'd1, 6'd4);
        wait_beats(2, 20);
        step(5);
        check("t6_nbeats", 64'(b_data.size()), 64'd2);
        check("t6_data0", b_data[0], mdat(32'h4000));
        check("t6_data1", b_data[1], mdat(32'h4008));
        check("t6_last0", 64'(b_last[0]), 64'd0);
        check("t6_last1", 64'(b_last[1]), 64'd1);
        check("t6_id", 64'(b_id[1]), 64'd9);
        check("t6_user", 64'(b_user[1]), 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
